pipe_stage_elastic: RTL

Parametrised successor to the fixed EX/MEM-style pipeline registers. It is a single elastic pipeline stage carrying a control field and a data field, with a valid/ready handshake on both sides. An optional skid entry, synchronous flush (bubble insertion) and a saturating bubble counter are included. It sits between any two pipeline stages of the multi-cycle/pipelined MIPS datapath (e.g. EX->MEM, MEM->WB).

---
 rtl/pipe_stage_pkg.sv | 15 +
 rtl/pipe_slot.sv | 25 ++
 rtl/pipe_stage_elastic.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared types for the elastic pipeline stage.
// State encoding and counter saturation constant.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // Widest supported bubble counter; narrower ones slice this.
    localparam int unsigned CNT_W_MAX = 32;
    localparam logic [CNT_W_MAX-1:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the elastic stage.
// Loads on load_i, async active-low reset to zero.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with optional skid entry,
// flush and saturating downstream-idle counter.
module pipe_stage_elastic
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int PW = CTRL_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_SAT_ALL[CNT_W-1:0];

    state_e          state_q, state_d;
    logic            accept, issue;
    logic            m_load, s_load, m_sel_s;
    logic [PW-1:0]   in_pkt, m_d, m_q, s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_pkt    = {in_ctrl, in_data};
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_rdy_reg
            assign in_ready = (state_q != TWO);
        end else begin : g_rdy_comb
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        m_load  = 1'b0;
        s_load  = 1'b0;
        m_sel_s = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        m_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        m_load = 1'b1;
                    end else if (accept) begin
                        state_d = TWO;
                        s_load  = 1'b1;
                    end else if (issue) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (issue) begin
                        state_d = ONE;
                        m_load  = 1'b1;
                        m_sel_s = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign m_d = m_sel_s ? s_q : in_pkt;

    pipe_slot #(.W(PW)) u_m (
        .clk_i  (CLK),
        .rst_ni (RST),
        .load_i (m_load),
        .d_i    (m_d),
        .q_o    (m_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.W(PW)) u_s (
                .clk_i  (CLK),
                .rst_ni (RST),
                .load_i (s_load),
                .d_i    (in_pkt),
                .q_o    (s_q)
            );
        end else begin : g_noskid
            logic unused_s;
            assign unused_s = s_load;
            assign s_q = '0;
        end
    endgenerate

    assign out_ctrl = out_valid ? m_q[PW-1 -: CTRL_W] : '0;
    assign out_data = m_q[DATA_W-1:0];

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_ready && !out_valid && cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt = cnt_q;

endmodule
